sw_capture_fifo: RTL and testbench
==================================

# sw_capture_fifo

Parametrised switch-input capture port for the PICO_MIPS top level, replacing direct sampling of the `sw` bus by the core. A raw strobe switch is synchronised and debounced. Each selected edge of the debounced strobe captures the synchronised data switches into a small first-word-fall-through FIFO. The core drains the FIFO through a simple read interface, and a sticky overflow flag records captures lost while the FIFO was full.

## Interface
- `DATA_W`, 8: width of captured data switches.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DEBOUNCE_CYC`, 1024: consecutive stable cycles needed to accept a strobe level change; ≥2.
- `SYNC_STAGES`, 2: synchroniser flops on the strobe and data inputs; ≥2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset. Driven from `sw[9]` at top level.
- `sw_data`  in  DATA_W  raw data switches, asynchronous.
- `sw_strobe`  in  1  raw strobe switch (`sw[8]`), asynchronous, bouncy.
- `edge_mode`  in  2  capture edge select: 00 rise, 01 fall, 10 both, 11 disabled.
- `rd_en`  in  1  pop request from core.
- `ovf_clr`  in  1  clears `overflow`.
- `rd_data`  out  DATA_W  head entry; valid while `rd_valid`=1.
- `rd_valid`  out  1  FIFO not empty.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `overflow`  out  1  sticky; set when a capture is dropped.

## Operation
- **Synchronisers.** `sw_strobe` and `sw_data` each pass through a SYNC_STAGES flop chain, giving `strobe_s` and `data_s`.
- **Debounce.**
  - `deb` is the debounced strobe level; `cnt` is its stability counter.
  - If `strobe_s`==`deb`: `cnt` clears to 0.
  - Otherwise `cnt` increments. On the cycle `cnt`==DEBOUNCE_CYC-1 with `strobe_s`!=`deb`, `deb` toggles and `cnt` clears.
  - A level shorter than DEBOUNCE_CYC cycles never reaches `deb`.
- **Capture.** `cap` is asserted on the cycle `deb` toggles, when the edge direction matches `edge_mode`. The entry written is `data_s` on that cycle. `edge_mode` is not registered; a change applies to the next toggle.
- **FIFO.** First-word fall-through; `rd_data` = entry at the read pointer. Pointers wrap modulo DEPTH.
  - Push on `cap` when not full.
  - Pop on `rd_en` when `rd_valid`=1. `rd_en` while empty is ignored.
  - Full + `cap` + no pop: capture dropped, `overflow` set, no pointer or count change.
  - Full + `cap` + pop on the same cycle: both take effect, `count` stays DEPTH, no overflow.
  - Empty + `cap` + `rd_en` on the same cycle: push only. `rd_en` is ignored because `rd_valid` was 0.
- **Overflow flag.** Set by a dropped capture; cleared by `ovf_clr`. If set and clear occur on the same cycle, set wins.
- **Reset.** While `rst_n`=0, all flops are cleared: synchronisers, `deb`, `cnt`, pointers, `count`, `overflow`. Reset outputs are `rd_valid`=0, `count`=0, `overflow`=0, `rd_data`=0. Storage contents need no reset. A reset mid-debounce discards the pending change, and no capture occurs on release. Release with `sw_strobe` high gives a rising edge once debounced.

## Timing
- Capture latency: a raw strobe change first sampled at clock edge 1 makes `deb` toggle and the FIFO write occur at edge SYNC_STAGES+DEBOUNCE_CYC. `rd_valid` and `count` update after that same edge.
- `sw_data` must be stable for at least SYNC_STAGES cycles before the accepting edge. This holds in practice because switches settle well within the debounce window.
- Pop: `rd_data` advances and `count` decrements after the edge on which `rd_en`=1 and `rd_valid`=1.
- Throughput: at most one capture per DEBOUNCE_CYC cycles, and one pop per cycle.

## Structure
- Package `pico_io_pkg`:
  - `edge_mode` constants EDGE_RISE=2'b00, EDGE_FALL=2'b01, EDGE_BOTH=2'b10, EDGE_OFF=2'b11.
  - Typedef `edge_mode_t`.
- Sub-module `sw_debounce`: synchroniser plus debounce counter, parameters SYNC_STAGES and DEBOUNCE_CYC. Outputs `deb`, `rise_pulse` and `fall_pulse`, each a one-cycle pulse on the toggle cycle.
- The top block holds the data synchroniser, capture select, FIFO storage, pointers and overflow logic.

## Test plan
All scenarios use DEBOUNCE_CYC=16, SYNC_STAGES=2, DEPTH=4, DATA_W=8.
- **Reset:** `rst_n`=0 mid-traffic → `rd_valid`=0, `count`=0, `overflow`=0 immediately (asynchronous). After release, no spurious capture while strobe is held low.
- **Clean rise:** `sw_data`=8'hA5, `edge_mode`=00, strobe 0→1 held → `rd_valid`=1 exactly 18 edges after the first sampling edge, `rd_data`=8'hA5, `count`=1. One `rd_en` → `count`=0.
- **Bounce rejection:** strobe high 10 cycles, low 3, high 10, low → no capture, `count` stays 0. Strobe high 16+ cycles → exactly one capture.
- **Overflow:** five clean rise/fall pulses with data 1..5, no reads → `count`=4, `overflow`=1. Reads return 1,2,3,4. `ovf_clr` → `overflow`=0.
- **Edge modes:** one high/low pulse with `edge_mode`=10 → 2 entries. With 01 → 1 entry (captured at the fall). With 11 → 0 entries.
- **Simultaneous events:** FIFO full, capture on the same cycle as `rd_en` → `count`=4, `overflow`=0, new data at the tail. FIFO empty, capture with `rd_en`=1 → `count`=1.

Source files
------------

// File: rtl/pico_io_pkg.sv
// Shared definitions for the PICO_MIPS switch-input capture path.
package pico_io_pkg;

    typedef logic [1:0] edge_mode_t;

    localparam edge_mode_t EDGE_RISE = 2'b00;
    localparam edge_mode_t EDGE_FALL = 2'b01;
    localparam edge_mode_t EDGE_BOTH = 2'b10;
    localparam edge_mode_t EDGE_OFF  = 2'b11;

endpackage

// File: rtl/sw_debounce.sv
// Strobe switch synchroniser and debouncer; pulses mark the cycle the debounced
// level toggles so the capture lands on the same edge as the level change.
module sw_debounce #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_strobe,
    output logic deb,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   strobe_s;
    logic                   toggle;

    assign strobe_s   = sync_q[SYNC_STAGES-1];
    assign toggle     = (strobe_s != deb) && (cnt == CNT_W'(DEBOUNCE_CYC - 1));
    assign rise_pulse = toggle && !deb;
    assign fall_pulse = toggle && deb;

    // Counter only advances while the synchronised level disagrees with deb
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt    <= '0;
            deb    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_strobe};
            if ((strobe_s == deb) || toggle) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (toggle) begin
                deb <= !deb;
            end
        end
    end

endmodule

// File: rtl/sw_capture_fifo.sv
// Switch capture port: debounced strobe edges push synchronised data switches
// into a first-word-fall-through FIFO drained by the core.
module sw_capture_fifo
    import pico_io_pkg::*;
#(
    parameter  int unsigned DATA_W       = 8,
    parameter  int unsigned DEPTH        = 4,
    parameter  int unsigned DEBOUNCE_CYC = 1024,
    parameter  int unsigned SYNC_STAGES  = 2,
    localparam int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              sw_strobe,
    input  edge_mode_t        edge_mode,
    input  logic              rd_en,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] data_q [SYNC_STAGES];
    logic [DATA_W-1:0] mem    [DEPTH];
    logic [DATA_W-1:0] data_s;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              deb;
    logic              rise_pulse;
    logic              fall_pulse;
    logic              dir_ok;
    logic              cap;
    logic              full;
    logic              push;
    logic              pop;
    logic              drop;

    sw_debounce #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_strobe  (sw_strobe),
        .deb        (deb),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            data_q[0] <= sw_data;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign data_s = data_q[SYNC_STAGES-1];

    // deb still holds the pre-toggle level, so deb==0 means a rising edge
    always_comb begin
        dir_ok = 1'b0;
        case (edge_mode)
            EDGE_RISE: dir_ok = !deb;
            EDGE_FALL: dir_ok = deb;
            EDGE_BOTH: dir_ok = 1'b1;
            default:   dir_ok = 1'b0;
        endcase
    end

    assign cap      = (rise_pulse || fall_pulse) && dir_ok;
    assign rd_valid = (count != '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign pop      = rd_en && rd_valid;
    assign push     = cap && (!full || pop);
    assign drop     = cap && full && !pop;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // A drop on the same cycle as a clear leaves the flag set
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sw_capture_fifo.sv
// Directed bench for sw_capture_fifo with a short debounce window.
module tb_sw_capture_fifo;

    localparam int unsigned DATA_W       = 8;
    localparam int unsigned DEPTH        = 4;
    localparam int unsigned DEBOUNCE_CYC = 16;
    localparam int unsigned SYNC_STAGES  = 2;
    localparam int unsigned CNT_W        = $clog2(DEPTH + 1);
    localparam int          LAT          = SYNC_STAGES + DEBOUNCE_CYC;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] sw_data;
    logic              sw_strobe;
    logic [1:0]        edge_mode;
    logic              rd_en;
    logic              ovf_clr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    int n_checks = 0;
    int n_pass   = 0;

    sw_capture_fifo #(
        .DATA_W       (DATA_W),
        .DEPTH        (DEPTH),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .SYNC_STAGES  (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_data   (sw_data),
        .sw_strobe (sw_strobe),
        .edge_mode (edge_mode),
        .rd_en     (rd_en),
        .ovf_clr   (ovf_clr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dhi;
        logic [7:0] dlo;
        logic [1:0] mode;
        int         npop;
        int         exp_count;
        logic       exp_ovf;
        logic [7:0] exp_head;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] dhi, input logic [7:0] dlo, input int hi, input int lo);
        sw_data   = dhi;
        sw_strobe = 1'b1;
        repeat (hi) tick();
        sw_data   = dlo;
        sw_strobe = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic apply_vec(input int i);
        for (int p = 0; p < vecs[i].npop; p++) pop_one();
        edge_mode = vecs[i].mode;
        pulse(vecs[i].dhi, vecs[i].dlo, LAT + 2, LAT + 2);
        check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
        check($sformatf("vec%0d ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
        check($sformatf("vec%0d valid", i), 32'(rd_valid), 32'(vecs[i].exp_count != 0));
        if (vecs[i].exp_count != 0)
            check($sformatf("vec%0d head", i), 32'(rd_data), 32'(vecs[i].exp_head));
    endtask

    initial begin
        vecs[0] = '{8'h01, 8'h01, 2'b00, 0, 1, 1'b0, 8'h01};
        vecs[1] = '{8'h02, 8'h02, 2'b00, 0, 2, 1'b0, 8'h01};
        vecs[2] = '{8'h03, 8'h03, 2'b00, 0, 3, 1'b0, 8'h01};
        vecs[3] = '{8'h04, 8'h04, 2'b00, 0, 4, 1'b0, 8'h01};
        vecs[4] = '{8'h05, 8'h05, 2'b00, 0, 4, 1'b1, 8'h01};
        vecs[5] = '{8'h21, 8'h22, 2'b10, 0, 2, 1'b0, 8'h21};
        vecs[6] = '{8'h31, 8'h32, 2'b01, 1, 2, 1'b0, 8'h22};
        vecs[7] = '{8'h41, 8'h42, 2'b11, 2, 0, 1'b0, 8'h00};
        vecs[8] = '{8'h51, 8'h52, 2'b00, 0, 1, 1'b0, 8'h51};

        rst_n = 1'b0; sw_data = '0; sw_strobe = 1'b0; edge_mode = 2'b00;
        rd_en = 1'b0; ovf_clr = 1'b0;
        #12;
        check("reset count", 32'(count), 32'd0);
        check("reset valid", 32'(rd_valid), 32'd0);
        check("reset ovf", 32'(overflow), 32'd0);
        check("reset rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // Read from an empty FIFO must be ignored
        pop_one();
        check("empty pop count", 32'(count), 32'd0);

        // Clean rise: write lands exactly LAT edges after first sampling edge
        sw_data = 8'hA5; sw_strobe = 1'b1;
        repeat (LAT - 1) tick();
        check("latency early valid", 32'(rd_valid), 32'd0);
        tick();
        check("latency valid", 32'(rd_valid), 32'd1);
        check("latency data", 32'(rd_data), 32'hA5);
        check("latency count", 32'(count), 32'd1);
        pop_one();
        check("latency pop count", 32'(count), 32'd0);
        sw_strobe = 1'b0;
        repeat (LAT + 2) tick();
        check("rise mode ignores fall", 32'(count), 32'd0);

        // Bounce rejection
        pulse(8'h3C, 8'h3C, 10, 3);
        pulse(8'h3C, 8'h3C, 10, LAT + 5);
        check("bounce count", 32'(count), 32'd0);
        pulse(8'h3C, 8'h3C, LAT + 2, LAT + 2);
        check("stable count", 32'(count), 32'd1);
        check("stable data", 32'(rd_data), 32'h3C);
        pop_one();

        // Fill and overflow
        for (int i = 0; i < 5; i++) apply_vec(i);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d data", i), 32'(rd_data), 32'(i + 1));
            pop_one();
        end
        check("drained count", 32'(count), 32'd0);
        check("ovf sticky", 32'(overflow), 32'd1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ovf cleared", 32'(overflow), 32'd0);

        // Edge modes
        for (int i = 5; i < 9; i++) apply_vec(i);

        // Full + capture + pop on the same edge
        edge_mode = 2'b00;
        pulse(8'h61, 8'h61, LAT + 2, LAT + 2);
        pulse(8'h62, 8'h62, LAT + 2, LAT + 2);
        pulse(8'h63, 8'h63, LAT + 2, LAT + 2);
        check("refill count", 32'(count), 32'd4);
        sw_data = 8'h70; sw_strobe = 1'b1;
        repeat (LAT - 1) tick();
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        check("full cap+pop count", 32'(count), 32'd4);
        check("full cap+pop ovf", 32'(overflow), 32'd0);
        check("full cap+pop head", 32'(rd_data), 32'h61);
        pop_one(); pop_one(); pop_one();
        check("tail data", 32'(rd_data), 32'h70);
        pop_one();
        sw_strobe = 1'b0;
        repeat (LAT + 2) tick();

        // Empty + capture + rd_en on the same edge
        sw_data = 8'h80; sw_strobe = 1'b1;
        repeat (LAT - 1) tick();
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        check("empty cap+rd count", 32'(count), 32'd1);
        check("empty cap+rd data", 32'(rd_data), 32'h80);
        sw_strobe = 1'b0;
        repeat (LAT + 2) tick();

        // Drop and clear on the same edge: set wins
        pulse(8'h81, 8'h81, LAT + 2, LAT + 2);
        pulse(8'h82, 8'h82, LAT + 2, LAT + 2);
        pulse(8'h83, 8'h83, LAT + 2, LAT + 2);
        sw_data = 8'h84; sw_strobe = 1'b1;
        repeat (LAT - 1) tick();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("set beats clear", 32'(overflow), 32'd1);
        check("drop keeps count", 32'(count), 32'd4);

        // Asynchronous reset mid-debounce with traffic pending
        sw_strobe = 1'b0;
        repeat (LAT + 2) tick();
        sw_strobe = 1'b1;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async rst count", 32'(count), 32'd0);
        check("async rst valid", 32'(rd_valid), 32'd0);
        check("async rst ovf", 32'(overflow), 32'd0);
        sw_strobe = 1'b0;
        rst_n = 1'b1;
        repeat (LAT + 10) tick();
        check("no spurious capture", 32'(count), 32'd0);

        // Release with strobe held high yields a rising capture
        sw_data = 8'h99; sw_strobe = 1'b1;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        repeat (LAT - 1) tick();
        check("rel-high early", 32'(count), 32'd0);
        tick();
        check("rel-high count", 32'(count), 32'd1);
        check("rel-high data", 32'(rd_data), 32'h99);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
